// File: rtl/alu_pkg.sv
// Shared ALU control codes, FSM encoding and an op-class helper for the EX-stage unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  function automatic logic is_mul(input logic [3:0] ctrl);
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/ex_alu_unit_if.sv
// EX-stage ALU handshake/data bundle; master is the issuing pipeline, slave is ex_alu_unit.
interface ex_alu_unit_if #(
  parameter int DATA_W = 64
);
  logic              valid_i;
  logic              ready_o;
  logic [3:0]        ctrl_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic              flush_i;
  logic              valid_o;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              stall_o;

  modport master (
    output valid_i, ctrl_i, op_a_i, op_b_i, flush_i,
    input  ready_o, valid_o, result_o, zero_o, stall_o
  );

  modport slave (
    input  valid_i, ctrl_i, op_a_i, op_b_i, flush_i,
    output ready_o, valid_o, result_o, zero_o, stall_o
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Shift-add multiplier datapath: one multiplier bit per cycle, DATA_W cycles (fewer with MUL_EARLY_EXIT_EN).
// done is combinational on the final iteration; product is that iteration's accumulator so it can be registered the same edge.
module ex_mul_iter #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [DATA_W-1:0] acc_nxt, mplier_nxt;
  logic [CNT_W-1:0]  cnt;

  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mplier_nxt = mplier >> 1;
  assign product    = acc_nxt;

`ifdef MUL_EARLY_EXIT_EN
  assign done = busy && ((cnt == CNT_W'(1)) || (mplier_nxt == '0));
`else
  assign done = busy && (cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (load) begin
      busy   <= 1'b1;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= CNT_W'(DATA_W);
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier_nxt;
      cnt    <= cnt - CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU: AND/OR/ADD/SUB registered with 1-cycle latency, iterative MUL (DATA_W cycles, early exit under MUL_EARLY_EXIT_EN).
// Latency: single-cycle ops valid_o one cycle after accept; MUL valid_o the cycle after its last iteration.
// Backpressure: ready_o low and stall_o high while a MUL iterates; no downstream backpressure, valid_o is a pulse.
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ex_alu_unit_if.slave   bus
);

  logic [0:0]        state;
  logic [DATA_W-1:0] alu_res, result_q, product;
  logic              valid_q, zero_q;
  logic              ready, accept, mul_load, mul_finish;
  logic              mul_busy, mul_done;

  assign ready      = (state == ST_IDLE);
  assign accept     = bus.valid_i && ready && !bus.flush_i;
  assign mul_load   = accept && is_mul(bus.ctrl_i);
  assign mul_finish = (state == ST_MUL) && mul_busy && mul_done && !bus.flush_i;

  assign bus.ready_o  = ready;
  assign bus.stall_o  = (state == ST_MUL);
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;

  // Undefined codes resolve to zero so beq sees zero_o=1 rather than stale data.
  always_comb begin
    alu_res = '0;
    case (bus.ctrl_i)
      ALU_AND: alu_res = bus.op_a_i & bus.op_b_i;
      ALU_OR:  alu_res = bus.op_a_i | bus.op_b_i;
      ALU_ADD: alu_res = bus.op_a_i + bus.op_b_i;
      ALU_SUB: alu_res = bus.op_a_i - bus.op_b_i;
      default: alu_res = '0;
    endcase
  end

  ex_mul_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (mul_load),
    .flush   (bus.flush_i),
    .a       (bus.op_a_i),
    .b       (bus.op_b_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul(bus.ctrl_i)) begin
              state <= ST_MUL;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              valid_q  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // Flush wins even over a finishing iteration: the result is dropped.
          if (bus.flush_i) begin
            state <= ST_IDLE;
          end else if (mul_finish) begin
            result_q <= product;
            zero_q   <= (product == '0);
            valid_q  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed testbench for ex_alu_unit (DATA_W=64); MUL latency expectations follow MUL_EARLY_EXIT_EN.
module tb_ex_alu_unit;
  import alu_pkg::*;

  localparam int DW = 64;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_63 = 2;
  localparam int LAT_60 = 1;
  localparam logic [DW-1:0] FLUSH_B = 64'h8000_0000_0000_0003;
`else
  localparam int LAT_63 = 64;
  localparam int LAT_60 = 64;
  localparam logic [DW-1:0] FLUSH_B = 64'd3;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ex_alu_unit_if #(.DATA_W(DW)) bus ();

  ex_alu_unit #(.DATA_W(DW), .CNT_W(7)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ctrl, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.valid_i = 1'b1;
    bus.ctrl_i  = ctrl;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
  endtask

  task automatic idle_in();
    bus.valid_i = 1'b0;
    bus.ctrl_i  = ALU_AND;
    bus.op_a_i  = '0;
    bus.op_b_i  = '0;
  endtask

  // Issue one op, return once the accepting edge has passed.
  task automatic issue(input logic [3:0] ctrl, input logic [DW-1:0] a, input logic [DW-1:0] b);
    drive(ctrl, a, b);
    step();
    idle_in();
  endtask

  // Starting in the cycle after acceptance, count cycles until valid_o.
  task automatic wait_valid(input string tag, output int lat, output int stalls);
    lat = 0;
    stalls = 0;
    while (!bus.valid_o && lat < 300) begin
      if (bus.stall_o && !bus.ready_o) stalls++;
      step();
      lat++;
    end
    if (!bus.valid_o) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Single-cycle op: result and flags in the first cycle after accept, pulse gone the next.
  task automatic single(input string tag, input logic [3:0] ctrl, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_res, input logic exp_zero);
    issue(ctrl, a, b);
    chk({tag, "_valid"}, 64'(bus.valid_o), 64'd1);
    chk({tag, "_res"}, bus.result_o, exp_res);
    chk({tag, "_zero"}, 64'(bus.zero_o), 64'(exp_zero));
    step();
    chk({tag, "_pulse"}, 64'(bus.valid_o), 64'd0);
  endtask

  initial begin
    int lat;
    int stalls;
    logic seen;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.flush_i = 1'b0;
    idle_in();
    #2 rst_n = 1'b0;
    #10;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_res", bus.result_o, 64'd0);
    chk("rst_zero", 64'(bus.zero_o), 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    #3 rst_n = 1'b1;
    step();
    chk("rst_ready", 64'(bus.ready_o), 64'd1);

    single("add", ALU_ADD, 64'd5, 64'd7, 64'd12, 1'b0);
    single("sub", ALU_SUB, 64'd9, 64'd9, 64'd0, 1'b1);

    // Back-to-back AND then OR.
    drive(ALU_AND, 64'hF0, 64'h3C);
    step();
    chk("and_valid", 64'(bus.valid_o), 64'd1);
    chk("and_res", bus.result_o, 64'h30);
    drive(ALU_OR, 64'hF0, 64'h3C);
    step();
    idle_in();
    chk("or_valid", 64'(bus.valid_o), 64'd1);
    chk("or_res", bus.result_o, 64'hFC);
    step();
    chk("or_pulse", 64'(bus.valid_o), 64'd0);

    single("undef", 4'b0101, 64'd1, 64'd1, 64'd0, 1'b1);
    single("add_wrap", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    single("sub_wrap", ALU_SUB, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Flush with valid in IDLE: nothing accepted.
    bus.flush_i = 1'b1;
    issue(ALU_ADD, 64'd4, 64'd4);
    bus.flush_i = 1'b0;
    chk("flush_idle_valid", 64'(bus.valid_o), 64'd0);
    chk("flush_idle_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFF);

    // MUL 3 * -2, then an ADD accepted in the valid_o cycle.
    issue(ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mul_neg_ready", 64'(bus.ready_o), 64'd0);
    wait_valid("mul_neg", lat, stalls);
    chk("mul_neg_lat", 64'(lat), 64'd64);
    chk("mul_neg_stalls", 64'(stalls), 64'd64);
    chk("mul_neg_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mul_neg_ready_end", 64'(bus.ready_o), 64'd1);
    chk("mul_neg_stall_end", 64'(bus.stall_o), 64'd0);
    single("add_after_mul", ALU_ADD, 64'd1, 64'd2, 64'd3, 1'b0);

    // Flush at iteration 10 of a MUL.
    issue(ALU_MUL, 64'd6, FLUSH_B);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | bus.valid_o;
    end
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    seen = seen | bus.valid_o;
    chk("flush_mul_novalid", 64'(seen), 64'd0);
    chk("flush_mul_res", bus.result_o, 64'd3);
    chk("flush_mul_ready", 64'(bus.ready_o), 64'd1);
    chk("flush_mul_stall", 64'(bus.stall_o), 64'd0);
    single("add_after_flush", ALU_ADD, 64'd1, 64'd1, 64'd2, 1'b0);

    // Latency depends on early exit.
    issue(ALU_MUL, 64'd6, 64'd0);
    wait_valid("mul_b0", lat, stalls);
    chk("mul_b0_lat", 64'(lat), 64'(LAT_60));
    chk("mul_b0_res", bus.result_o, 64'd0);
    chk("mul_b0_zero", 64'(bus.zero_o), 64'd1);

    issue(ALU_MUL, 64'd6, 64'd3);
    wait_valid("mul_63", lat, stalls);
    chk("mul_63_lat", 64'(lat), 64'(LAT_63));
    chk("mul_63_res", bus.result_o, 64'd18);
    chk("mul_63_zero", 64'(bus.zero_o), 64'd0);

    // Async reset at iteration 20 of a 64-iteration MUL.
    issue(ALU_MUL, 64'd5, 64'h8000_0000_0000_0001);
    for (int i = 0; i < 20; i++) step();
    chk("rst_mid_stall_before", 64'(bus.stall_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_mid_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_mid_res", bus.result_o, 64'd0);
    #2 rst_n = 1'b1;
    step();
    chk("rst_mid_ready", 64'(bus.ready_o), 64'd1);
    single("add_after_rst", ALU_ADD, 64'd2, 64'd3, 64'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
